// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-bus signals of the load/store unit.
// The master modport is the core/bus side; the slave modport is the LSU.
interface load_store_unit_if;
    logic        start;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] ALU_result;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic [31:0] read_data;
    logic        fault_misalign;
    logic        fault_timeout;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output start, mem_write, funct3, ALU_result, write_data, bus_ack, bus_rdata,
        input  busy, done, read_data, fault_misalign, fault_timeout,
               bus_req, bus_we, bus_addr, bus_wdata, bus_be
    );

    modport slave (
        input  start, mem_write, funct3, ALU_result, write_data, bus_ack, bus_rdata,
        output busy, done, read_data, fault_misalign, fault_timeout,
               bus_req, bus_we, bus_addr, bus_wdata, bus_be
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one load or store per request over a req/ack bus, with
// store alignment, byte enables, load extension, and misalign/timeout faults.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic               clk,
    input logic               reset,
    load_store_unit_if.slave  lsu
);
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic            bus_we_q, bus_we_d;
    logic [31:0]     bus_addr_q, bus_addr_d;
    logic [31:0]     bus_wdata_q, bus_wdata_d;
    logic [3:0]      bus_be_q, bus_be_d;
    logic [31:0]     read_data_q, read_data_d;
    logic            done_q, done_d;
    logic            fault_misalign_q, fault_misalign_d;
    logic            fault_timeout_q, fault_timeout_d;

    logic            req_bad;
    logic [1:0]      req_lo;
    logic [3:0]      req_be;
    logic [31:0]     req_wdata;
    logic [31:0]     rd_shifted;
    logic [31:0]     load_val;

    // Request decode: legality, alignment, lane enables and replicated store data.
    always_comb begin
        req_lo    = lsu.ALU_result[1:0];
        req_be    = 4'b1111;
        req_wdata = lsu.write_data;
        unique case (lsu.funct3[1:0])
            2'b00: begin
                req_be    = 4'b0001 << req_lo;
                req_wdata = {4{lsu.write_data[7:0]}};
            end
            2'b01: begin
                req_be    = req_lo[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{lsu.write_data[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = lsu.write_data;
            end
        endcase
        if (!lsu.mem_write) begin
            req_be = 4'b1111;
        end

        req_bad = 1'b0;
        if (lsu.mem_write && (lsu.funct3 > 3'b010)) begin
            req_bad = 1'b1;
        end
        if (!lsu.mem_write && ((lsu.funct3 == 3'b011) || (lsu.funct3[2:1] == 2'b11))) begin
            req_bad = 1'b1;
        end
        if ((lsu.funct3[1:0] == 2'b01) && req_lo[0]) begin
            req_bad = 1'b1;
        end
        if ((lsu.funct3[1:0] == 2'b10) && (req_lo != 2'b00)) begin
            req_bad = 1'b1;
        end
    end

    always_comb begin
        rd_shifted = lsu.bus_rdata >> {addr_lo_q, 3'b000};
        unique case (funct3_q)
            3'b000:  load_val = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b100:  load_val = {24'h0, rd_shifted[7:0]};
            3'b001:  load_val = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b101:  load_val = {16'h0, rd_shifted[15:0]};
            default: load_val = lsu.bus_rdata;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        funct3_d         = funct3_q;
        addr_lo_d        = addr_lo_q;
        bus_we_d         = bus_we_q;
        bus_addr_d       = bus_addr_q;
        bus_wdata_d      = bus_wdata_q;
        bus_be_d         = bus_be_q;
        read_data_d      = read_data_q;
        done_d           = 1'b0;
        fault_misalign_d = 1'b0;
        fault_timeout_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (lsu.start) begin
                    if (req_bad) begin
                        fault_misalign_d = 1'b1;
                        done_d           = 1'b1;
                        state_d          = StDone;
                    end else begin
                        funct3_d    = lsu.funct3;
                        addr_lo_d   = req_lo;
                        bus_we_d    = lsu.mem_write;
                        bus_addr_d  = {lsu.ALU_result[31:2], 2'b00};
                        bus_wdata_d = req_wdata;
                        bus_be_d    = req_be;
                        cnt_d       = '0;
                        state_d     = StReq;
                    end
                end
            end
            StReq: begin
                // Ack takes priority over a coincident timeout.
                if (lsu.bus_ack) begin
                    if (!bus_we_q) begin
                        read_data_d = load_val;
                    end
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    fault_timeout_d = 1'b1;
                    done_d          = 1'b1;
                    state_d         = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            funct3_q         <= 3'b000;
            addr_lo_q        <= 2'b00;
            bus_we_q         <= 1'b0;
            bus_addr_q       <= 32'h0;
            bus_wdata_q      <= 32'h0;
            bus_be_q         <= 4'b0000;
            read_data_q      <= 32'h0;
            done_q           <= 1'b0;
            fault_misalign_q <= 1'b0;
            fault_timeout_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            funct3_q         <= funct3_d;
            addr_lo_q        <= addr_lo_d;
            bus_we_q         <= bus_we_d;
            bus_addr_q       <= bus_addr_d;
            bus_wdata_q      <= bus_wdata_d;
            bus_be_q         <= bus_be_d;
            read_data_q      <= read_data_d;
            done_q           <= done_d;
            fault_misalign_q <= fault_misalign_d;
            fault_timeout_q  <= fault_timeout_d;
        end
    end

    assign lsu.busy           = (state_q != StIdle);
    assign lsu.bus_req        = (state_q == StReq);
    assign lsu.done           = done_q;
    assign lsu.read_data      = read_data_q;
    assign lsu.fault_misalign = fault_misalign_q;
    assign lsu.fault_timeout  = fault_timeout_q;
    assign lsu.bus_we         = bus_we_q;
    assign lsu.bus_addr       = bus_addr_q;
    assign lsu.bus_wdata      = bus_wdata_q;
    assign lsu.bus_be         = bus_be_q;
endmodule
